// File: rtl/counter_pkg.sv
// Shared action encoding for the modulo up/down counter and its bench.
package counter_pkg;

  typedef enum logic [1:0] {
    CTR_HOLD = 2'd0,
    CTR_UP   = 2'd1,
    CTR_DOWN = 2'd2,
    CTR_LOAD = 2'd3
  } ctr_action_t;

  localparam int CTR_ACTION_W = 2;

endpackage

// File: rtl/counter_mod_next.sv
// Next-state logic for the modulo counter: next value, wrap/clamp flag, error flag.
module counter_mod_next
  import counter_pkg::*;
#(
  parameter int word_width = 8,
  parameter int step_width = 4
) (
  input  logic [word_width-1:0] cur_count,
  input  ctr_action_t           action,
  input  logic                  saturate,
  input  logic [step_width-1:0] step,
  input  logic [word_width-1:0] limit,
  input  logic [word_width-1:0] d_in,
  output logic [word_width-1:0] next_count,
  output logic                  next_wrap,
  output logic                  next_err
);

  logic [word_width:0] cur_x;
  logic [word_width:0] step_x;
  logic [word_width:0] lim_x;
  logic [word_width:0] mod_x;
  logic [word_width:0] sum_x;
  logic [word_width:0] wrap_up_x;
  logic [word_width:0] wrap_dn_x;
  logic [word_width:0] sub_x;
  logic                out_of_range;
  logic                illegal_step;
  logic                clamp;

  // One extra bit so limit = all-ones still gives a representable modulus.
  assign cur_x        = {1'b0, cur_count};
  assign step_x       = {{(word_width + 1 - step_width){1'b0}}, step};
  assign lim_x        = {1'b0, limit};
  assign mod_x        = lim_x + 1'b1;
  assign sum_x        = cur_x + step_x;
  assign sub_x        = cur_x - step_x;
  assign wrap_up_x    = sum_x - mod_x;
  assign wrap_dn_x    = cur_x + mod_x - step_x;
  assign out_of_range = cur_x > lim_x;
  assign illegal_step = step_x > lim_x;
  assign clamp        = saturate | illegal_step;

  always_comb begin
    next_count = cur_count;
    next_wrap  = 1'b0;
    next_err   = 1'b0;
    unique case (action)
      CTR_UP: begin
        next_err = illegal_step;
        if (out_of_range) begin
          next_count = '0;
          next_wrap  = 1'b1;
        end else if (sum_x > lim_x) begin
          next_count = clamp ? limit : wrap_up_x[word_width-1:0];
          next_wrap  = 1'b1;
        end else begin
          next_count = sum_x[word_width-1:0];
        end
      end
      CTR_DOWN: begin
        next_err = illegal_step;
        if (out_of_range) begin
          next_count = limit;
          next_wrap  = 1'b1;
        end else if (step_x > cur_x) begin
          next_count = clamp ? '0 : wrap_dn_x[word_width-1:0];
          next_wrap  = 1'b1;
        end else begin
          next_count = sub_x[word_width-1:0];
        end
      end
      CTR_LOAD: begin
        if (d_in > limit) begin
          next_count = limit;
          next_err   = 1'b1;
        end else begin
          next_count = d_in;
        end
      end
      default: begin
        next_count = cur_count;
      end
    endcase
  end

endmodule

// File: rtl/counter_mod_updown.sv
// Modulo up/down counter over [0, limit]: one-cycle update, wrap or saturate, sticky err.
module counter_mod_updown
  import counter_pkg::*;
#(
  parameter int word_width = 8,
  parameter int step_width = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            action,
  input  logic                  saturate,
  input  logic [step_width-1:0] step,
  input  logic [word_width-1:0] limit,
  input  logic [word_width-1:0] D_IN,
  input  logic                  clear_err,
  output logic [word_width-1:0] D_OUT,
  output logic                  will_overflow,
  output logic                  wrapped,
  output logic                  err
);

  ctr_action_t           act;
  logic [word_width-1:0] next_count;
  logic                  next_wrap;
  logic                  next_err;

  assign act = ctr_action_t'(action);

  counter_mod_next #(
    .word_width (word_width),
    .step_width (step_width)
  ) u_next (
    .cur_count  (D_OUT),
    .action     (act),
    .saturate   (saturate),
    .step       (step),
    .limit      (limit),
    .d_in       (D_IN),
    .next_count (next_count),
    .next_wrap  (next_wrap),
    .next_err   (next_err)
  );

  assign will_overflow = enable & ((act == CTR_UP) | (act == CTR_DOWN)) & next_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      D_OUT   <= '0;
      wrapped <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (enable) begin
        D_OUT   <= next_count;
        wrapped <= next_wrap;
      end else begin
        wrapped <= 1'b0;
      end
      // A new error in the same cycle as clear_err keeps err set.
      if (enable && next_err) begin
        err <= 1'b1;
      end else if (clear_err) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_mod_updown.sv
// Directed bench for counter_mod_updown with an arithmetic reference model checked every cycle.
module tb_counter_mod_updown;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] action;
  logic       saturate;
  logic [3:0] step;
  logic [7:0] limit;
  logic [7:0] D_IN;
  logic       clear_err;
  logic [7:0] D_OUT;
  logic       will_overflow;
  logic       wrapped;
  logic       err;

  int checks = 0;
  int errors = 0;

  int m_cnt = 0;
  int m_wr  = 0;
  int m_err = 0;
  bit m_valid = 1'b0;

  counter_mod_updown #(.word_width(8), .step_width(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .action        (action),
    .saturate      (saturate),
    .step          (step),
    .limit         (limit),
    .D_IN          (D_IN),
    .clear_err     (clear_err),
    .D_OUT         (D_OUT),
    .will_overflow (will_overflow),
    .wrapped       (wrapped),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Reference rules in plain integer arithmetic; modulus is limit+1.
  function automatic void model_next(input int cur, input int act, input int sat, input int stp,
                                     input int lim, input int din,
                                     output int nxt, output int wr, output int es);
    int m;
    m   = lim + 1;
    nxt = cur;
    wr  = 0;
    es  = 0;
    if (act == 1) begin
      es = (stp > lim) ? 1 : 0;
      if (cur > lim) begin
        nxt = 0; wr = 1;
      end else if (cur + stp > lim) begin
        wr  = 1;
        nxt = (sat != 0 || stp > lim) ? lim : (cur + stp) % m;
      end else begin
        nxt = cur + stp;
      end
    end else if (act == 2) begin
      es = (stp > lim) ? 1 : 0;
      if (cur > lim) begin
        nxt = lim; wr = 1;
      end else if (stp > cur) begin
        wr  = 1;
        nxt = (sat != 0 || stp > lim) ? 0 : (cur - stp + m) % m;
      end else begin
        nxt = cur - stp;
      end
    end else if (act == 3) begin
      if (din > lim) begin
        nxt = lim; es = 1;
      end else begin
        nxt = din;
      end
    end
  endfunction

  always begin
    int nxt, wr, es;
    @(posedge clk);
    if (reset === 1'b1) begin
      m_cnt = 0; m_wr = 0; m_err = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (enable === 1'b1) begin
        model_next(m_cnt, int'(action), int'(saturate), int'(step), int'(limit), int'(D_IN), nxt, wr, es);
        m_cnt = nxt;
        m_wr  = wr;
        if (es != 0) m_err = 1;
        else if (clear_err === 1'b1) m_err = 0;
      end else begin
        m_wr = 0;
        if (clear_err === 1'b1) m_err = 0;
      end
    end
    #1;
    if (m_valid) begin
      chk("model_dout", D_OUT, m_cnt);
      chk("model_wrapped", wrapped, m_wr);
      chk("model_err", err, m_err);
    end
    @(negedge clk);
    #1;
    if (m_valid) begin
      model_next(m_cnt, int'(action), int'(saturate), int'(step), int'(limit), int'(D_IN), nxt, wr, es);
      chk("model_will_overflow", will_overflow,
          (enable === 1'b1 && (action == CTR_UP || action == CTR_DOWN) && wr != 0) ? 1 : 0);
    end
  end

  // Drive one cycle's inputs on the falling edge.
  task automatic cyc(input bit rst, input bit en, input ctr_action_t act, input bit sat,
                     input int stp, input int lim, input int din, input bit clr);
    @(negedge clk);
    reset     = rst;
    enable    = en;
    action    = act;
    saturate  = sat;
    step      = 4'(stp);
    limit     = 8'(lim);
    D_IN      = 8'(din);
    clear_err = clr;
  endtask

  task automatic after_edge(input string name, input int exp_d, input int exp_w, input int exp_e);
    @(posedge clk);
    #2;
    chk({name, "_dout"}, D_OUT, exp_d);
    chk({name, "_wrapped"}, wrapped, exp_w);
    chk({name, "_err"}, err, exp_e);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; action = CTR_HOLD; saturate = 1'b0;
    step = '0; limit = 8'd9; D_IN = '0; clear_err = 1'b0;
    cyc(1, 0, CTR_HOLD, 0, 0, 9, 0, 0);
    after_edge("reset", 0, 0, 0);

    // Wrap on UP with will_overflow flagged beforehand
    cyc(0, 1, CTR_LOAD, 0, 0, 9, 8, 0);
    after_edge("t1_load", 8, 0, 0);
    cyc(0, 1, CTR_UP, 0, 3, 9, 0, 0);
    #1 chk("t1_wov", will_overflow, 1);
    after_edge("t1_up_wrap", 1, 1, 0);
    cyc(0, 1, CTR_HOLD, 0, 3, 9, 0, 0);
    #1 chk("t1_wov_hold", will_overflow, 0);
    after_edge("t1_pulse_end", 1, 0, 0);

    // Saturate vs wrap on both directions
    cyc(0, 1, CTR_LOAD, 1, 0, 9, 8, 0);
    after_edge("t2_load", 8, 0, 0);
    cyc(0, 1, CTR_UP, 1, 3, 9, 0, 0);
    after_edge("t2_up_sat", 9, 1, 0);
    cyc(0, 1, CTR_LOAD, 1, 0, 9, 1, 0);
    after_edge("t2_load1", 1, 0, 0);
    cyc(0, 1, CTR_DOWN, 1, 3, 9, 0, 0);
    after_edge("t2_down_sat", 0, 1, 0);
    cyc(0, 1, CTR_LOAD, 0, 0, 9, 1, 0);
    after_edge("t2_load1b", 1, 0, 0);
    cyc(0, 1, CTR_DOWN, 0, 3, 9, 0, 0);
    after_edge("t2_down_wrap", 8, 1, 0);
    cyc(0, 1, CTR_UP, 0, 0, 9, 0, 0);
    after_edge("t2_step0", 8, 0, 0);

    // Full-range modulus 256
    cyc(0, 1, CTR_LOAD, 0, 0, 255, 255, 0);
    after_edge("t3_load", 255, 0, 0);
    cyc(0, 1, CTR_UP, 0, 1, 255, 0, 0);
    after_edge("t3_up_wrap", 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, CTR_UP, 0, 1, 255, 0, 0);
      #1 chk("t3_wov_disabled", will_overflow, 0);
      after_edge("t3_disabled", 0, 0, 0);
    end
    cyc(0, 1, CTR_DOWN, 0, 1, 255, 0, 0);
    after_edge("t3_down_wrap", 255, 1, 0);

    // Illegal load, clear, legal load
    cyc(0, 1, CTR_LOAD, 0, 0, 99, 200, 0);
    after_edge("t4_bad_load", 99, 0, 1);
    cyc(0, 1, CTR_HOLD, 0, 0, 99, 0, 1);
    after_edge("t4_clear", 99, 0, 0);
    cyc(0, 1, CTR_LOAD, 0, 0, 99, 42, 0);
    after_edge("t4_load42", 42, 0, 0);

    // Out-of-range state after limit lowered, and illegal step
    cyc(0, 1, CTR_LOAD, 0, 0, 255, 50, 0);
    after_edge("t5_load50", 50, 0, 0);
    cyc(0, 1, CTR_UP, 0, 3, 20, 0, 0);
    #1 chk("t5_wov_oor", will_overflow, 1);
    after_edge("t5_oor_up", 0, 1, 0);
    cyc(0, 1, CTR_LOAD, 0, 0, 255, 50, 0);
    after_edge("t5_reload50", 50, 0, 0);
    cyc(0, 1, CTR_DOWN, 0, 3, 20, 0, 0);
    after_edge("t5_oor_down", 20, 1, 0);
    cyc(0, 1, CTR_LOAD, 0, 0, 9, 5, 0);
    after_edge("t5_load5", 5, 0, 0);
    cyc(0, 1, CTR_UP, 0, 12, 9, 0, 0);
    after_edge("t5_bad_step_up", 9, 1, 1);
    cyc(0, 1, CTR_DOWN, 0, 12, 9, 0, 1);
    after_edge("t5_bad_step_down_clr", 0, 1, 1);

    // Reset beats a concurrent LOAD with err set
    cyc(0, 1, CTR_LOAD, 0, 0, 9, 5, 0);
    after_edge("t6_load5", 5, 0, 1);
    cyc(1, 1, CTR_LOAD, 0, 0, 9, 7, 0);
    after_edge("t6_reset", 0, 0, 0);

    cyc(0, 0, CTR_HOLD, 0, 0, 9, 0, 0);
    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
